keccak_rc_seq: RTL and testbench

- Sequential Keccak round-constant source for the iterative permutation cores.
- Generates each round's iota constant on the fly from the standard rc(t) LFSR, instead of decoding a one-hot round index.
- Parametrised over lane width (Keccak-f[200..1600]) and round count (Keccak-p reduced-round variants).
- Presents one constant per round over a valid/ready handshake. Sits between the round controller and the iota step.

---
 rtl/keccak_rc_seq_pkg.sv | 41 ++++
 rtl/keccak_rc_seq_step7.sv | 28 ++
 rtl/keccak_rc_seq.sv | 117 +++++++++++
 tb/tb_keccak_rc_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_rc_seq_pkg.sv
// Shared Keccak round-constant definitions: lane geometry, rc(t) LFSR step and seed.
// All functions are usable at elaboration time for parameter and seed computation.
package keccak_rc_seq_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } seq_state_t;

  // Feedback taps of x^8+x^6+x^5+x^4+1 with bit i holding the x^i coefficient.
  localparam logic [7:0] LFSR_TAPS = 8'h71;
  localparam logic [7:0] LFSR_INIT = 8'h01;

  function automatic int lane_log2(input int lane_w);
    case (lane_w)
      8:       return 3;
      16:      return 4;
      32:      return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int num_rounds(input int l);
    return 12 + 2 * l;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? LFSR_TAPS : 8'h00);
  endfunction

  // State at t = 7*ir0, so the first issued round needs no runtime pre-stepping.
  function automatic logic [7:0] seed_state(input int ir0);
    logic [7:0] s;
    s = LFSR_INIT;
    for (int t = 0; t < 7 * ir0; t++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

endpackage

// File: rtl/keccak_rc_seq_step7.sv
// Combinational 7-step rc(t) LFSR advance; also taps rc(t)..rc(t+L) for the current round.
// rc_bits[j] = rc(t+j) where state holds the LFSR at time t.
module rc_lfsr_step7
  import keccak_rc_seq_pkg::*;
#(
  parameter int L = 6
) (
  input  logic [7:0] state,
  output logic [7:0] next_state,
  output logic [L:0] rc_bits
);

  logic [7:0] walk;

  always_comb begin
    walk    = state;
    rc_bits = '0;
    for (int j = 0; j <= L; j++) begin
      rc_bits[j] = walk[0];
      walk       = lfsr_step(walk);
    end
    for (int k = L + 1; k < 7; k++) begin
      walk = lfsr_step(walk);
    end
    next_state = walk;
  end

endmodule

// File: rtl/keccak_rc_seq.sv
// Sequential Keccak iota constant source: one round constant per cycle over valid/ready.
// Holds rc/round/last while stalled; start restarts from IR0 at any time.
module keccak_rc_seq
  import keccak_rc_seq_pkg::*;
#(
  parameter int LANE_W  = 64,
  parameter int NROUNDS = 12 + 2 * lane_log2(LANE_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [LANE_W-1:0] rc,
  output logic              rc_valid,
  input  logic              rc_ready,
  output logic [4:0]        round,
  output logic              last,
  output logic              done,
  output logic              busy
);

  localparam int         L       = lane_log2(LANE_W);
  localparam int         NR      = num_rounds(L);
  localparam int         IR0     = NR - NROUNDS;
  localparam int         IR_LAST = NR - 1;
  localparam logic [7:0] SEED    = seed_state(IR0);

  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
    $error("keccak_rc_seq: LANE_W must be 8, 16, 32 or 64");
  end
  if (NROUNDS < 1 || NROUNDS > NR) begin : g_bad_rounds
    $error("keccak_rc_seq: NROUNDS out of range");
  end

  seq_state_t  state, state_n;
  logic        load, adv, finish;
  logic [7:0]  lfsr, step_in, step_next;
  logic [L:0]  step_bits;
  logic [LANE_W-1:0] rc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (start) begin
          load = 1'b1;
        end else if (rc_ready) begin
          if (last) begin
            finish  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A load steps from the constant seed; otherwise the register holds the next round's time.
  assign step_in = load ? SEED : lfsr;

  rc_lfsr_step7 #(.L(L)) u_step (
    .state      (step_in),
    .next_state (step_next),
    .rc_bits    (step_bits)
  );

  always_comb begin
    rc_next = '0;
    for (int j = 0; j <= L; j++) begin
      rc_next[(1 << j) - 1] = step_bits[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr  <= 8'h00;
      rc    <= '0;
      round <= 5'd0;
      last  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        lfsr  <= step_next;
        rc    <= rc_next;
        round <= 5'(IR0);
        last  <= (NROUNDS == 1);
      end else if (adv) begin
        lfsr  <= step_next;
        rc    <= rc_next;
        round <= round + 5'd1;
        last  <= (round + 5'd1 == 5'(IR_LAST));
      end else if (finish) begin
        last <= 1'b0;
      end
    end
  end

  assign rc_valid = (state == ST_ACTIVE);
  assign busy     = (state == ST_ACTIVE);

endmodule

// File: tb/tb_keccak_rc_seq.sv
// Bench for keccak_rc_seq: three configurations against a reference rc(t) model plus literals.
module tb_keccak_rc_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_s [3];
  logic        ready_s [3];
  logic [63:0] rc_a, rc_c;
  logic [7:0]  rc_b;
  logic [63:0] rc_o    [3];
  logic [4:0]  round_o [3];
  logic        valid_o [3];
  logic        last_o  [3];
  logic        done_o  [3];
  logic        busy_o  [3];

  int lg_t  [3] = '{6, 3, 6};
  int nr_t  [3] = '{24, 18, 12};
  int ir0_t [3] = '{0, 0, 12};

  int checks = 0;
  int errors = 0;

  keccak_rc_seq #(.LANE_W(64)) dut_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .rc(rc_a), .rc_valid(valid_o[0]),
    .rc_ready(ready_s[0]), .round(round_o[0]), .last(last_o[0]), .done(done_o[0]), .busy(busy_o[0])
  );
  keccak_rc_seq #(.LANE_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_s[1]), .rc(rc_b), .rc_valid(valid_o[1]),
    .rc_ready(ready_s[1]), .round(round_o[1]), .last(last_o[1]), .done(done_o[1]), .busy(busy_o[1])
  );
  keccak_rc_seq #(.LANE_W(64), .NROUNDS(12)) dut_c (
    .clk(clk), .reset(reset), .start(start_s[2]), .rc(rc_c), .rc_valid(valid_o[2]),
    .rc_ready(ready_s[2]), .round(round_o[2]), .last(last_o[2]), .done(done_o[2]), .busy(busy_o[2])
  );

  assign rc_o[0] = rc_a;
  assign rc_o[1] = {56'h0, rc_b};
  assign rc_o[2] = rc_c;

  // Textbook rc(t): R=10000000, shift toward higher index, fold R[8] into bits 0,4,5,6.
  function automatic bit rc_bit(input int t);
    bit r [9];
    if (t % 255 == 0) return 1'b1;
    for (int i = 0; i < 9; i++) r[i] = (i == 0);
    for (int i = 1; i <= t; i++) begin
      for (int k = 8; k > 0; k--) r[k] = r[k-1];
      r[0] = 1'b0;
      r[0] ^= r[8]; r[4] ^= r[8]; r[5] ^= r[8]; r[6] ^= r[8];
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc_word(input int ir, input int lg);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j <= lg; j++) w[(1 << j) - 1] = rc_bit(j + 7 * ir);
    return w;
  endfunction

  logic [63:0] rc_tab [3][24];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level expectation of each DUT's visible outputs.
  bit          m_valid [3];
  bit          m_last  [3];
  bit          m_done  [3];
  int          m_round [3];
  logic [63:0] m_rc    [3];

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        m_valid[d] <= 1'b0; m_last[d] <= 1'b0; m_done[d] <= 1'b0;
        m_round[d] <= 0;    m_rc[d]   <= '0;
      end else begin
        m_done[d] <= 1'b0;
        if (start_s[d]) begin
          m_valid[d] <= 1'b1;
          m_round[d] <= ir0_t[d];
          m_rc[d]    <= rc_tab[d][ir0_t[d]];
          m_last[d]  <= (nr_t[d] == 1);
        end else if (m_valid[d] && ready_s[d] && m_last[d]) begin
          m_valid[d] <= 1'b0;
          m_last[d]  <= 1'b0;
          m_done[d]  <= 1'b1;
        end else if (m_valid[d] && ready_s[d]) begin
          m_round[d] <= m_round[d] + 1;
          m_rc[d]    <= rc_tab[d][m_round[d] + 1];
          m_last[d]  <= (m_round[d] + 1 == ir0_t[d] + nr_t[d] - 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d_ctrl(v,b,l,d,round)", d),
            {55'd0, valid_o[d], busy_o[d], last_o[d], done_o[d], round_o[d]},
            {55'd0, m_valid[d], m_valid[d], m_last[d], m_done[d], 5'(m_round[d])});
      check($sformatf("dut%0d_rc", d), rc_o[d], m_rc[d]);
    end
  end

  initial begin
    for (int d = 0; d < 3; d++)
      for (int ir = 0; ir < 24; ir++) rc_tab[d][ir] = rc_word(ir, lg_t[d]);
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      ready_s[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_valid", 64'(valid_o[0]), 64'd0);
    check("rst_busy", 64'(busy_o[0]), 64'd0);
    check("rst_rc", rc_o[0], 64'd0);
    check("rst_round", 64'(round_o[1]), 64'd0);
    check("rst_done", 64'(done_o[2]), 64'd0);

    check("model_r0", rc_tab[0][0], 64'h0000000000000001);
    check("model_r1", rc_tab[0][1], 64'h0000000000008082);
    check("model_r5", rc_tab[0][5], 64'h0000000080000001);
    check("model_r6", rc_tab[0][6], 64'h8000000080008081);
    check("model_r12", rc_tab[0][12], 64'h000000008000808B);
    check("model_r23", rc_tab[0][23], 64'h8000000080008008);
    check("model_w8_r1", rc_tab[1][1], 64'h82);
    check("model_w8_r17", rc_tab[1][17], 64'h80);

    reset = 1'b0;
    @(negedge clk);

    // Run 1: all three configurations, ready held high.
    for (int d = 0; d < 3; d++) begin
      ready_s[d] = 1'b1;
      start_s[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
    for (int k = 0; k < 26; k++) begin
      case (k)
        0: begin
          check("a_first_round", 64'(round_o[0]), 64'd0);
          check("a_first_rc", rc_o[0], 64'h1);
          check("b_first_rc", rc_o[1], 64'h01);
          check("c_first_round", 64'(round_o[2]), 64'd12);
          check("c_first_rc", rc_o[2], 64'h000000008000808B);
        end
        1: begin
          check("a_r1_rc", rc_o[0], 64'h8082);
          check("b_r1_rc", rc_o[1], 64'h82);
        end
        11: begin
          check("c_last_round", 64'(round_o[2]), 64'd23);
          check("c_last_flag", 64'(last_o[2]), 64'd1);
          check("c_last_rc", rc_o[2], 64'h8000000080008008);
        end
        12: check("c_done", 64'(done_o[2]), 64'd1);
        17: begin
          check("b_last_round", 64'(round_o[1]), 64'd17);
          check("b_last_rc", rc_o[1], 64'h80);
          check("b_last_flag", 64'(last_o[1]), 64'd1);
        end
        18: check("b_done", 64'(done_o[1]), 64'd1);
        22: check("a_r22_not_last", 64'(last_o[0]), 64'd0);
        23: begin
          check("a_last_round", 64'(round_o[0]), 64'd23);
          check("a_last_rc", rc_o[0], 64'h8000000080008008);
          check("a_last_flag", 64'(last_o[0]), 64'd1);
        end
        24: begin
          check("a_done", 64'(done_o[0]), 64'd1);
          check("a_busy_drop", 64'(busy_o[0]), 64'd0);
        end
        25: check("a_done_one_cycle", 64'(done_o[0]), 64'd0);
        default: ;
      endcase
      @(negedge clk);
    end

    // Back-pressure at round 5 for three cycles.
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int k = 0; k < 29; k++) begin
      if (k >= 5 && k <= 8) begin
        check($sformatf("bp_round_k%0d", k), 64'(round_o[0]), 64'd5);
        check($sformatf("bp_rc_k%0d", k), rc_o[0], 64'h0000000080000001);
      end
      if (k == 5) ready_s[0] = 1'b0;
      if (k == 8) ready_s[0] = 1'b1;
      if (k == 9) check("bp_r6_rc", rc_o[0], 64'h8000000080008081);
      if (k == 27) check("bp_done", 64'(done_o[0]), 64'd1);
      @(negedge clk);
    end

    // Restart mid-sequence on A; restart on the final accept on B.
    start_s[0] = 1'b1;
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    for (int k = 0; k < 38; k++) begin
      if (k == 10) begin
        check("rs_a_round10", 64'(round_o[0]), 64'd10);
        start_s[0] = 1'b1;
      end
      if (k == 11) begin
        start_s[0] = 1'b0;
        check("rs_a_round0", 64'(round_o[0]), 64'd0);
        check("rs_a_rc0", rc_o[0], 64'h1);
        check("rs_a_no_done", 64'(done_o[0]), 64'd0);
      end
      if (k == 17) start_s[1] = 1'b1;
      if (k == 18) begin
        start_s[1] = 1'b0;
        check("rs_b_round0", 64'(round_o[1]), 64'd0);
        check("rs_b_no_done", 64'(done_o[1]), 64'd0);
        check("rs_b_valid", 64'(valid_o[1]), 64'd1);
      end
      if (k == 35) check("rs_a_done", 64'(done_o[0]), 64'd1);
      if (k == 36) check("rs_b_done", 64'(done_o[1]), 64'd1);
      @(negedge clk);
    end

    // Asynchronous reset between edges at round 7.
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (7) @(negedge clk);
    check("ar_round7", 64'(round_o[0]), 64'd7);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 64'(valid_o[0]), 64'd0);
    check("ar_busy", 64'(busy_o[0]), 64'd0);
    check("ar_rc", rc_o[0], 64'd0);
    check("ar_round", 64'(round_o[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ready_s[0] = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("ar_idle_valid_%0d", i), 64'(valid_o[0]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
